cpld_iowr_decoder: RTL and testbench

CPLD_IOWR_DECODER -- requirements
Module: cpld_iowr_decoder

---
 rtl/cpld_ram_pkg.sv | 24 ++
 rtl/cpld_sync.sv | 28 ++
 rtl/cpld_iowr_decoder.sv | 135 +++++++++++++
 tb/tb_cpld_iowr_decoder.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpld_ram_pkg.sv
// Shared definitions for the Z80 IO-write bank-select decoder.
// Holds the FSM encoding, default timing parameters and the select prefix.
// No logic; a saturating-count helper is provided for the write counter.
package cpld_ram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_QUAL     = 2'd1,
        ST_WAIT_REL = 2'd2,
        ST_BAD      = 2'd3
    } state_t;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_QUAL_CYCLES = 3;

    // Data bits [7:6] must carry this prefix for a write to select a bank.
    localparam logic [1:0] SEL_PREFIX = 2'b11;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/cpld_sync.sv
// N-stage flop synchroniser for a single bit or a vector, synchronous reset value.
// Latency: STAGES rising edges from input to output.
// Backpressure: none; samples every cycle.
module cpld_sync #(
    parameter int              WIDTH   = 1,
    parameter int              STAGES  = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES-1:0][WIDTH-1:0] stg;

    // Shift chain: stage 0 takes the raw input, the last stage is the output.
    always_ff @(posedge clk) begin
        if (reset) begin
            stg <= {STAGES{RST_VAL}};
        end else begin
            stg <= {stg[STAGES-2:0], d};
        end
    end

    assign q = stg[STAGES-1];

endmodule

// File: rtl/cpld_iowr_decoder.sv
// Decodes Z80 IO writes (A15 low) and latches a 6-bit RAM bank/scheme select.
// Latency: ramblock updates SYNC_STAGES+QUAL_CYCLES-1 edges after the qualify term is first sampled.
// Backpressure: none; ramblock_vld is a one-cycle pulse, at most one write accepted per IO cycle.
module cpld_iowr_decoder
    import cpld_ram_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int QUAL_CYCLES = DEF_QUAL_CYCLES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       iorq_b,
    input  logic       wr_b,
    input  logic       adr15,
    input  logic [7:0] data,
    input  logic       busreset_b,
    output logic [5:0] ramblock,
    output logic       ramblock_vld,
    output logic [7:0] wr_count,
    output logic [1:0] state_o
);

    localparam logic [3:0] QUAL_LIM = 4'(QUAL_CYCLES);

    logic [2:0] strobes_s;
    logic [7:0] data_s;
    logic       busreset_b_s;
    logic       q;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] qcnt;
    logic [3:0] qcnt_nxt;
    logic       complete;

    // Control strobes idle high; {iorq_b, wr_b, adr15}.
    cpld_sync #(.WIDTH(3), .STAGES(SYNC_STAGES), .RST_VAL(3'b111)) u_sync_strobes (
        .clk   (clk),
        .reset (reset),
        .d     ({iorq_b, wr_b, adr15}),
        .q     (strobes_s)
    );

    cpld_sync #(.WIDTH(8), .STAGES(SYNC_STAGES), .RST_VAL(8'h00)) u_sync_data (
        .clk   (clk),
        .reset (reset),
        .d     (data),
        .q     (data_s)
    );

    cpld_sync #(.WIDTH(1), .STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_busreset (
        .clk   (clk),
        .reset (reset),
        .d     (busreset_b),
        .q     (busreset_b_s)
    );

    // IO write to the lower half of the IO space, all terms active-low.
    assign q = ~strobes_s[2] & ~strobes_s[1] & ~strobes_s[0];

    // State and qualify-counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            qcnt  <= 4'd0;
        end else begin
            state <= state_nxt;
            qcnt  <= qcnt_nxt;
        end
    end

    // Next state: count consecutive qualify samples, fire once, then wait for release.
    always_comb begin
        state_nxt = state;
        qcnt_nxt  = qcnt;
        complete  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (q) begin
                    state_nxt = ST_QUAL;
                    qcnt_nxt  = 4'd1;
                end
            end
            ST_QUAL: begin
                if (!q) begin
                    state_nxt = ST_IDLE;
                    qcnt_nxt  = 4'd0;
                end else if ((qcnt + 4'd1) == QUAL_LIM) begin
                    state_nxt = ST_WAIT_REL;
                    qcnt_nxt  = 4'd0;
                    complete  = 1'b1;
                end else begin
                    qcnt_nxt  = qcnt + 4'd1;
                end
            end
            ST_WAIT_REL: begin
                if (!q) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                qcnt_nxt  = 4'd0;
            end
        endcase
        // Expansion-bus reset aborts any write in progress, including one completing now.
        if (!busreset_b_s) begin
            state_nxt = ST_IDLE;
            qcnt_nxt  = 4'd0;
            complete  = 1'b0;
        end
    end

    // Bank-select register, valid pulse and accepted-write counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            ramblock     <= 6'd0;
            ramblock_vld <= 1'b0;
            wr_count     <= 8'd0;
        end else if (!busreset_b_s) begin
            ramblock     <= 6'd0;
            ramblock_vld <= 1'b0;
        end else begin
            ramblock_vld <= 1'b0;
            if (complete && (data_s[7:6] == SEL_PREFIX)) begin
                ramblock     <= data_s[5:0];
                ramblock_vld <= 1'b1;
                wr_count     <= sat_inc8(wr_count);
            end
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_cpld_iowr_decoder.sv
// Self-checking bench for cpld_iowr_decoder: directed scenarios plus random IO traffic.
// Reference model tracks raw inputs through a delay queue and counts qualify run lengths.
// Outputs compared every cycle on the falling edge.
module tb_cpld_iowr_decoder;

    localparam int SS = 2;
    localparam int QC = 3;
    localparam logic [11:0] INACT = 12'hF00;  // {busreset_b, iorq_b, wr_b, adr15, data}

    logic       clk = 1'b0;
    logic       reset;
    logic       iorq_b;
    logic       wr_b;
    logic       adr15;
    logic [7:0] data;
    logic       busreset_b;
    logic [5:0] ramblock;
    logic       ramblock_vld;
    logic [7:0] wr_count;
    logic [1:0] state_o;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [11:0] pipe[$];
    logic [5:0]  m_ramblock;
    logic        m_vld;
    int          m_cnt;
    int          m_run;

    // scenario observation
    int vld_seen;
    bit saw_wait;
    bit saw_qual;
    bit saw_busy;

    cpld_iowr_decoder #(.SYNC_STAGES(SS), .QUAL_CYCLES(QC)) dut (
        .clk          (clk),
        .reset        (reset),
        .iorq_b       (iorq_b),
        .wr_b         (wr_b),
        .adr15        (adr15),
        .data         (data),
        .busreset_b   (busreset_b),
        .ramblock     (ramblock),
        .ramblock_vld (ramblock_vld),
        .wr_count     (wr_count),
        .state_o      (state_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model: the decoder sees each raw sample SS edges later; a write fires when
    // the QC-th consecutive qualified sample arrives (never again until a gap).
    task automatic model_edge();
        logic [11:0] s;
        if (reset) begin
            pipe.delete();
            for (int i = 0; i < SS; i++) pipe.push_back(INACT);
            m_ramblock = 6'd0;
            m_vld      = 1'b0;
            m_cnt      = 0;
            m_run      = 0;
            return;
        end
        pipe.push_back({busreset_b, iorq_b, wr_b, adr15, data});
        s = pipe.pop_front();
        m_vld = 1'b0;
        if (!s[11]) begin
            m_ramblock = 6'd0;
            m_run      = 0;
        end else if (!s[10] && !s[9] && !s[8]) begin
            if (m_run <= QC) m_run++;
            if (m_run == QC && s[7:6] == 2'b11) begin
                m_ramblock = s[5:0];
                m_vld      = 1'b1;
                if (m_cnt < 255) m_cnt++;
            end
        end else begin
            m_run = 0;
        end
    endtask

    function automatic int m_state();
        if (m_run == 0) return 0;
        if (m_run < QC) return 1;
        return 2;
    endfunction

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        if (ramblock_vld === 1'b1) vld_seen++;
        if (state_o === 2'd2) saw_wait = 1'b1;
        if (state_o === 2'd1) saw_qual = 1'b1;
        if (state_o !== 2'd0) saw_busy = 1'b1;
        chk({tag, ".ramblock"}, 32'(ramblock), 32'(m_ramblock));
        chk({tag, ".vld"}, 32'(ramblock_vld), 32'(m_vld));
        chk({tag, ".wr_count"}, 32'(wr_count), 32'(m_cnt));
        chk({tag, ".state"}, 32'(state_o), 32'(m_state()));
    endtask

    task automatic drive(input logic io, input logic w, input logic a,
                         input logic [7:0] d, input logic br);
        iorq_b     = io;
        wr_b       = w;
        adr15      = a;
        data       = d;
        busreset_b = br;
    endtask

    task automatic obs_clear();
        vld_seen = 0;
        saw_wait = 1'b0;
        saw_qual = 1'b0;
        saw_busy = 1'b0;
    endtask

    task automatic idle(input int n, input string tag);
        drive(1'b1, 1'b1, 1'b1, 8'h00, 1'b1);
        repeat (n) tick(tag);
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 8'h00, 1'b1);
        obs_clear();

        // reset state
        tick("rst");
        tick("rst");
        chk("rst_ramblock", 32'(ramblock), 32'd0);
        chk("rst_vld", 32'(ramblock_vld), 32'd0);
        chk("rst_wr_count", 32'(wr_count), 32'd0);
        chk("rst_state", 32'(state_o), 32'd0);
        reset = 1'b0;
        idle(3, "post_rst");

        // accepted write of 0xCA, qualify held 6 cycles
        obs_clear();
        drive(1'b0, 1'b0, 1'b0, 8'hCA, 1'b1);
        for (int i = 0; i < 6; i++) begin
            tick("wr_ca");
            if (i == 3) chk("wr_ca_before_latency", 32'(ramblock), 32'h00);
            if (i == 4) chk("wr_ca_at_latency", 32'(ramblock), 32'h0A);
        end
        idle(6, "wr_ca_rel");
        chk("wr_ca_vld_pulses", 32'(vld_seen), 32'd1);
        chk("wr_ca_wr_count", 32'(wr_count), 32'd1);

        // wrong prefix: completes but changes nothing
        obs_clear();
        drive(1'b0, 1'b0, 1'b0, 8'h4A, 1'b1);
        repeat (6) tick("wr_4a");
        idle(6, "wr_4a_rel");
        chk("wr_4a_ramblock", 32'(ramblock), 32'h0A);
        chk("wr_4a_vld_pulses", 32'(vld_seen), 32'd0);
        chk("wr_4a_wr_count", 32'(wr_count), 32'd1);
        chk("wr_4a_wait_rel", 32'(saw_wait), 32'd1);

        // glitch: only two qualified samples
        obs_clear();
        drive(1'b0, 1'b0, 1'b0, 8'hD5, 1'b1);
        repeat (2) tick("glitch");
        idle(6, "glitch_rel");
        chk("glitch_saw_qual", 32'(saw_qual), 32'd1);
        chk("glitch_no_wait", 32'(saw_wait), 32'd0);
        chk("glitch_ramblock", 32'(ramblock), 32'h0A);

        // upper IO half: ignored
        obs_clear();
        drive(1'b0, 1'b0, 1'b1, 8'hC7, 1'b1);
        repeat (6) tick("adr15");
        idle(4, "adr15_rel");
        chk("adr15_idle", 32'(saw_busy), 32'd0);
        chk("adr15_ramblock", 32'(ramblock), 32'h0A);

        // bus reset after ramblock=0x3F
        drive(1'b0, 1'b0, 1'b0, 8'hFF, 1'b1);
        repeat (6) tick("wr_ff");
        idle(4, "wr_ff_rel");
        chk("wr_ff_ramblock", 32'(ramblock), 32'h3F);
        drive(1'b1, 1'b1, 1'b1, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick("busrst");
            if (i == 1) chk("busrst_sync_delay", 32'(ramblock), 32'h3F);
            if (i == 2) chk("busrst_cleared", 32'(ramblock), 32'h00);
        end
        idle(4, "busrst_rel");
        chk("busrst_wr_count_kept", 32'(wr_count), 32'd2);

        // collision: bus reset seen on the completing edge
        drive(1'b0, 1'b0, 1'b0, 8'hC9, 1'b1);
        repeat (6) tick("wr_c9");
        idle(4, "wr_c9_rel");
        chk("wr_c9_ramblock", 32'(ramblock), 32'h09);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 1'b0, 8'hC5, (i == 2) ? 1'b0 : 1'b1);
            tick("collide");
        end
        idle(6, "collide_rel");
        chk("collide_ramblock", 32'(ramblock), 32'h00);
        chk("collide_wr_count", 32'(wr_count), 32'd3);

        // random IO traffic
        for (int seg = 0; seg < 300; seg++) begin
            logic [7:0] d;
            logic [2:0] p;
            int len;
            d = 8'($urandom);
            if ($urandom_range(0, 1) == 1) d[7:6] = 2'b11;
            p = ($urandom_range(0, 3) < 2) ? 3'b000 : 3'($urandom);
            len = $urandom_range(1, 6);
            drive(p[2], p[1], p[0], d, ($urandom_range(0, 15) != 0));
            repeat (len) tick("rand");
        end
        idle(5, "rand_rel");

        // 256 accepted writes, wr_count saturates
        for (int n = 0; n < 256; n++) begin
            drive(1'b0, 1'b0, 1'b0, {2'b11, 6'($urandom)}, 1'b1);
            repeat (4) tick("sat_wr");
            idle(3, "sat_rel");
        end
        chk("sat_wr_count", 32'(wr_count), 32'd255);

        // reset in the middle of a qualifying write
        drive(1'b0, 1'b0, 1'b0, 8'hEE, 1'b1);
        repeat (3) tick("mid_qual");
        chk("mid_qual_state", 32'(state_o), 32'd1);
        reset = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 8'h00, 1'b1);
        repeat (2) tick("mid_rst");
        reset = 1'b0;
        idle(6, "after_rst");
        chk("after_rst_ramblock", 32'(ramblock), 32'd0);
        chk("after_rst_vld", 32'(ramblock_vld), 32'd0);
        chk("after_rst_wr_count", 32'(wr_count), 32'd0);
        chk("after_rst_state", 32'(state_o), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
